// File: rtl/component_bit_packer_if.sv
// Bundle carrying the VLC code inputs, sequencer controls and the packed
// word stream of the component bit packer.
interface component_bit_packer_if #(
    parameter int LEN_W = 6
);
    logic             slice_start;
    logic             dc_en;
    logic [31:0]      dc_code;
    logic [LEN_W-1:0] dc_len;
    logic             ac_en;
    logic [31:0]      ac_code;
    logic [LEN_W-1:0] ac_len;
    logic             flush;
    logic [31:0]      out_word;
    logic             out_valid;
    logic             out_last;
    logic             done;
    logic [31:0]      total_bits;
    logic [31:0]      word_count;
    logic             error;

    // Producer side: VLC stages / sequencer drive codes, consume the word stream.
    modport master (
        output slice_start, dc_en, dc_code, dc_len, ac_en, ac_code, ac_len, flush,
        input  out_word, out_valid, out_last, done, total_bits, word_count, error
    );

    // Packer side.
    modport slave (
        input  slice_start, dc_en, dc_code, dc_len, ac_en, ac_code, ac_len, flush,
        output out_word, out_valid, out_last, done, total_bits, word_count, error
    );
endinterface

// File: rtl/component_bit_packer.sv
// Packs right-justified variable-length DC/AC codes MSB-first into 32-bit
// words. Pending bits live right-justified in the low fill_p0 bits of the
// accumulator; a word leaves as soon as 32 bits are pending, and a flush
// closes the component with a zero-padded final word.
module component_bit_packer #(
    parameter int LEN_W = 6,
    parameter int ACC_W = 64
) (
    input logic                   clock,
    input logic                   reset_n,
    component_bit_packer_if.slave bus
);
    localparam int FILL_W = 7;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ACC_W-1:0]  acc_p0;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  acc_app;
    logic [FILL_W-1:0] fill_p0;
    logic [FILL_W-1:0] fill_next;
    logic [FILL_W-1:0] fill_sum;
    logic [LEN_W-1:0]  raw_len;
    logic [LEN_W-1:0]  sel_len;
    logic [31:0]       sel_code;
    logic              take;
    logic [31:0]       word_next;
    logic              valid_next;
    logic              last_next;
    logic              done_next;
    logic [31:0]       total_next;
    logic [31:0]       count_next;
    logic              error_next;

    // Lengths beyond a full word are treated as a full word.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(32)) ? LEN_W'(32) : len;
    endfunction

    // Keep only the low len bits of a right-justified code (len=32 keeps all).
    function automatic logic [31:0] mask_code(input logic [31:0] code,
                                              input logic [LEN_W-1:0] len);
        return code & ~(32'hFFFF_FFFF << len);
    endfunction

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state, code selection, append, word emission and flush padding.
    always_comb begin
        state_next = state;
        acc_next   = acc_p0;
        fill_next  = fill_p0;
        acc_app    = acc_p0;
        fill_sum   = fill_p0;
        raw_len    = '0;
        sel_len    = '0;
        sel_code   = '0;
        take       = 1'b0;
        word_next  = '0;
        valid_next = 1'b0;
        last_next  = 1'b0;
        done_next  = 1'b0;
        total_next = bus.total_bits;
        count_next = bus.word_count;
        error_next = bus.error;

        if (bus.slice_start) begin
            // New slice: pending bits are thrown away, inputs this cycle ignored.
            state_next = RUN;
            acc_next   = '0;
            fill_next  = '0;
            total_next = '0;
            count_next = '0;
            error_next = 1'b0;
        end else if (state == FLUSH) begin
            if (bus.dc_en || bus.ac_en || bus.flush) begin
                error_next = 1'b1;
            end
            if (fill_p0 != '0) begin
                word_next  = 32'(acc_p0 << (7'd32 - fill_p0));
                valid_next = 1'b1;
                last_next  = 1'b1;
                count_next = bus.word_count + 32'd1;
            end
            done_next  = 1'b1;
            acc_next   = '0;
            fill_next  = '0;
            state_next = RUN;
        end else begin
            if (bus.dc_en) begin
                take     = 1'b1;
                raw_len  = bus.dc_len;
                sel_code = bus.dc_code;
                if (bus.ac_en) begin
                    error_next = 1'b1;
                end
            end else if (bus.ac_en) begin
                take     = 1'b1;
                raw_len  = bus.ac_len;
                sel_code = bus.ac_code;
            end
            if (take && (raw_len > LEN_W'(32))) begin
                error_next = 1'b1;
            end
            sel_len    = take ? clamp_len(raw_len) : '0;
            acc_app    = (acc_p0 << sel_len) | ACC_W'(mask_code(sel_code, sel_len));
            fill_sum   = fill_p0 + FILL_W'(sel_len);
            acc_next   = acc_app;
            fill_next  = fill_sum;
            total_next = bus.total_bits + 32'(sel_len);
            if (fill_sum >= 7'd32) begin
                word_next  = 32'(acc_app >> (fill_sum - 7'd32));
                valid_next = 1'b1;
                fill_next  = fill_sum - 7'd32;
                count_next = bus.word_count + 32'd1;
            end
            if (bus.flush) begin
                state_next = FLUSH;
                // Nothing left to pad: the word leaving now closes the component.
                if (valid_next && (fill_next == '0)) begin
                    last_next = 1'b1;
                end
            end
        end
    end

    // Accumulator and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_p0         <= '0;
            fill_p0        <= '0;
            bus.out_word   <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.done       <= 1'b0;
            bus.total_bits <= '0;
            bus.word_count <= '0;
            bus.error      <= 1'b0;
        end else begin
            acc_p0         <= acc_next;
            fill_p0        <= fill_next;
            bus.out_word   <= word_next;
            bus.out_valid  <= valid_next;
            bus.out_last   <= last_next;
            bus.done       <= done_next;
            bus.total_bits <= total_next;
            bus.word_count <= count_next;
            bus.error      <= error_next;
        end
    end
endmodule

// File: tb/tb_component_bit_packer.sv
// Bench for component_bit_packer: a bit-queue reference model predicts every
// registered output each cycle, and directed scenarios pin literal words.
module tb_component_bit_packer;
    logic clock;
    logic reset_n;

    component_bit_packer_if #(.LEN_W(6)) bus ();

    component_bit_packer #(.LEN_W(6), .ACC_W(64)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks;
    int failures;

    // Reference model state: pending bits in coding order, flush-cycle flag,
    // and the expected registered outputs.
    bit          pend[$];
    bit          m_flushing;
    logic [31:0] e_word;
    bit          e_valid;
    bit          e_last;
    bit          e_done;
    logic [31:0] e_total;
    logic [31:0] e_count;
    bit          e_error;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_flushing = 0;
        e_word  = '0;
        e_valid = 0;
        e_last  = 0;
        e_done  = 0;
        e_total = '0;
        e_count = '0;
        e_error = 0;
    endtask

    task automatic model_step();
        int          n;
        logic [31:0] c;
        bit          use_code;
        e_valid = 0;
        e_last  = 0;
        e_done  = 0;
        e_word  = '0;
        if (bus.slice_start) begin
            pend.delete();
            m_flushing = 0;
            e_total = '0;
            e_count = '0;
            e_error = 0;
        end else if (m_flushing) begin
            if (bus.dc_en || bus.ac_en || bus.flush) e_error = 1;
            if (pend.size() > 0) begin
                for (int i = 0; i < 32; i++) e_word[31-i] = (i < pend.size()) ? pend[i] : 1'b0;
                e_valid = 1;
                e_last  = 1;
                e_count = e_count + 1;
            end
            pend.delete();
            e_done = 1;
            m_flushing = 0;
        end else begin
            n = 0;
            c = '0;
            use_code = 0;
            if (bus.dc_en) begin
                use_code = 1;
                n = int'(bus.dc_len);
                c = bus.dc_code;
                if (bus.ac_en) e_error = 1;
            end else if (bus.ac_en) begin
                use_code = 1;
                n = int'(bus.ac_len);
                c = bus.ac_code;
            end
            if (use_code && n > 32) begin
                e_error = 1;
                n = 32;
            end
            for (int i = n - 1; i >= 0; i--) pend.push_back(c[i]);
            e_total = e_total + 32'(n);
            if (pend.size() >= 32) begin
                for (int i = 0; i < 32; i++) e_word[31-i] = pend.pop_front();
                e_valid = 1;
                e_count = e_count + 1;
            end
            if (bus.flush) begin
                m_flushing = 1;
                if (e_valid && pend.size() == 0) e_last = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(bus.out_valid), 32'(e_valid));
        check("out_last", 32'(bus.out_last), 32'(e_last));
        check("done", 32'(bus.done), 32'(e_done));
        check("total_bits", bus.total_bits, e_total);
        check("word_count", bus.word_count, e_count);
        check("error", 32'(bus.error), 32'(e_error));
        if (e_valid) check("out_word", bus.out_word, e_word);
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clock);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        bus.slice_start = 0;
        bus.dc_en   = 0;
        bus.dc_code = '0;
        bus.dc_len  = '0;
        bus.ac_en   = 0;
        bus.ac_code = '0;
        bus.ac_len  = '0;
        bus.flush   = 0;
    endtask

    task automatic new_slice();
        idle();
        bus.slice_start = 1;
        tick();
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clock    = 0;
        reset_n  = 0;
        idle();
        model_reset();
        repeat (2) tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_total", bus.total_bits, 32'd0);
        #2 reset_n = 1;
        tick();

        // 1: single 3-bit DC code (junk above len), then flush.
        bus.dc_en = 1; bus.dc_len = 6'd3; bus.dc_code = 32'hFFFF_FFF5;
        tick();
        idle(); bus.flush = 1;
        tick();
        check("t1_no_word_yet", 32'(bus.out_valid), 32'd0);
        idle();
        tick();
        check("t1_word", bus.out_word, 32'hA000_0000);
        check("t1_last", 32'(bus.out_last), 32'd1);
        check("t1_done", 32'(bus.done), 32'd1);
        check("t1_total", bus.total_bits, 32'd3);
        tick();

        // 2: eight back-to-back 8-bit AC codes.
        new_slice();
        for (int k = 1; k <= 8; k++) begin
            bus.ac_en = 1; bus.ac_len = 6'd8; bus.ac_code = 32'(k * 8'h11);
            tick();
            if (k == 4) check("t2_word0", bus.out_word, 32'h1122_3344);
            if (k == 8) check("t2_word1", bus.out_word, 32'h5566_7788);
        end
        check("t2_count", bus.word_count, 32'd2);
        idle(); bus.flush = 1;
        tick();
        idle();
        tick();
        check("t2_done_no_word", 32'(bus.out_valid), 32'd0);
        check("t2_done", 32'(bus.done), 32'd1);

        // 3: 31 pending ones, then a 32-bit zero code together with flush.
        new_slice();
        bus.dc_en = 1; bus.dc_len = 6'd31; bus.dc_code = 32'h7FFF_FFFF;
        tick();
        idle(); bus.ac_en = 1; bus.ac_len = 6'd32; bus.ac_code = 32'h0; bus.flush = 1;
        tick();
        check("t3_word0", bus.out_word, 32'hFFFF_FFFE);
        check("t3_word0_last", 32'(bus.out_last), 32'd0);
        idle();
        tick();
        check("t3_word1", bus.out_word, 32'h0000_0000);
        check("t3_word1_last", 32'(bus.out_last), 32'd1);
        check("t3_done", 32'(bus.done), 32'd1);

        // 4: DC/AC collision, DC wins, error is sticky.
        new_slice();
        bus.dc_en = 1; bus.dc_len = 6'd4; bus.dc_code = 32'hF;
        bus.ac_en = 1; bus.ac_len = 6'd4; bus.ac_code = 32'h0;
        tick();
        idle(); bus.flush = 1;
        tick();
        idle();
        tick();
        check("t4_word", bus.out_word, 32'hF000_0000);
        check("t4_error", 32'(bus.error), 32'd1);
        tick();
        check("t4_error_sticky", 32'(bus.error), 32'd1);

        // 5: over-long AC length clamps to 32; slice_start clears.
        new_slice();
        bus.ac_en = 1; bus.ac_len = 6'd40; bus.ac_code = 32'hFFFF_FFFF;
        tick();
        check("t5_word", bus.out_word, 32'hFFFF_FFFF);
        check("t5_error", 32'(bus.error), 32'd1);
        check("t5_total", bus.total_bits, 32'd32);
        new_slice();
        check("t5_clr_error", 32'(bus.error), 32'd0);
        check("t5_clr_total", bus.total_bits, 32'd0);
        check("t5_clr_count", bus.word_count, 32'd0);

        // 6: asynchronous reset with 10 bits pending.
        bus.dc_en = 1; bus.dc_len = 6'd10; bus.dc_code = 32'h3FF;
        tick();
        idle();
        #2 reset_n = 0;
        #1;
        model_reset();
        compare_all();
        check("t6_total_now", bus.total_bits, 32'd0);
        tick();
        #2 reset_n = 1;
        bus.flush = 1;
        tick();
        idle();
        tick();
        check("t6_no_word", 32'(bus.out_valid), 32'd0);
        check("t6_done", 32'(bus.done), 32'd1);

        // 7: len=0 is a no-op; inputs during the flush cycle are errors.
        new_slice();
        bus.dc_en = 1; bus.dc_len = 6'd0; bus.dc_code = 32'hFFFF_FFFF;
        tick();
        check("t7_len0_total", bus.total_bits, 32'd0);
        check("t7_len0_error", 32'(bus.error), 32'd0);
        idle(); bus.flush = 1;
        tick();
        idle(); bus.ac_en = 1; bus.ac_len = 6'd8; bus.ac_code = 32'hAB;
        tick();
        check("t7_flush_input_error", 32'(bus.error), 32'd1);
        check("t7_flush_total", bus.total_bits, 32'd0);

        // 8: flush that empties the accumulator marks the word leaving with it.
        new_slice();
        bus.dc_en = 1; bus.dc_len = 6'd16; bus.dc_code = 32'h1234;
        tick();
        bus.dc_code = 32'h5678; bus.flush = 1;
        tick();
        check("t8_word", bus.out_word, 32'h1234_5678);
        check("t8_last", 32'(bus.out_last), 32'd1);
        idle();
        tick();
        check("t8_done_no_word", 32'(bus.out_valid), 32'd0);
        check("t8_done", 32'(bus.done), 32'd1);

        // 9: mixed lengths 0..33 with occasional collisions, closed by a flush.
        new_slice();
        for (int i = 0; i < 40; i++) begin
            idle();
            if (i % 2 == 0 || i % 11 == 5) begin
                bus.dc_en = 1; bus.dc_len = 6'((i * 7) % 34); bus.dc_code = 32'(i) * 32'h9E37_79B9;
            end
            if (i % 2 == 1 || i % 11 == 5) begin
                bus.ac_en = 1; bus.ac_len = 6'((i * 5) % 34); bus.ac_code = ~(32'(i) * 32'h85EB_CA6B);
            end
            bus.flush = (i == 39);
            tick();
        end
        idle();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
